// File: rtl/frame_max_tracker_pkg.sv
// Shared definitions for the frame maximum tracker: FSM state encoding
// and the sample width used by the tracker and its comparator.
package frame_max_tracker_pkg;

   localparam int SAMPLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/comparator.sv
// Single-shot unsigned magnitude comparator: Out is high when A is
// strictly greater than B.
module comparator (
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic       Out
);

   // Strict compare so that equal values never report "greater".
   always_comb begin
      Out = (A > B);
   end

endmodule

// File: rtl/frame_max_tracker.sv
// Framed streaming reduction: finds the largest 4-bit sample in each frame,
// the position of its first occurrence and the (saturating) frame length,
// then holds the result until the consumer takes it.
module frame_max_tracker
   import frame_max_tracker_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SAMPLE_W-1:0] in_data,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SAMPLE_W-1:0] out_max,
   output logic [IDX_W-1:0]    out_idx,
   output logic [IDX_W:0]      out_cnt,
   output logic                out_ovf
);

   // Count value meaning "frame already holds 2^IDX_W samples".
   localparam logic [IDX_W:0]   CNT_FULL = {1'b1, {IDX_W{1'b0}}};
   // Highest index that fits in out_idx.
   localparam logic [IDX_W-1:0] IDX_TOP  = {IDX_W{1'b1}};

   state_t                state;
   logic [SAMPLE_W-1:0]   max_q;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W:0]        cnt_q;
   logic                  ovf_q;
   logic                  greater;
   logic                  accept;
   logic                  cnt_full;
   logic [IDX_W-1:0]      new_idx;

   // The existing comparator decides whether the incoming sample beats
   // the running maximum; ties lose so the earliest occurrence is kept.
   comparator u_cmp (
      .A   (in_data),
      .B   (max_q),
      .Out (greater)
   );

   // Handshake and index-clamping helpers; in_ready drops during reset so
   // nothing is accepted while the state is being cleared.
   always_comb begin
      in_ready  = (state != DONE) && !reset;
      out_valid = (state == DONE);
      accept    = in_valid && in_ready;
      cnt_full  = (cnt_q == CNT_FULL);
      new_idx   = cnt_full ? IDX_TOP : cnt_q[IDX_W-1:0];
   end

   // FSM, sample counter and running result registers in one place.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         max_q <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  max_q <= in_data;
                  idx_q <= '0;
                  cnt_q <= {{IDX_W{1'b0}}, 1'b1};
                  ovf_q <= 1'b0;
                  state <= in_last ? DONE : ACC;
               end
            end
            ACC: begin
               if (accept) begin
                  if (greater) begin
                     max_q <= in_data;
                     idx_q <= new_idx;
                  end
                  if (cnt_full) begin
                     ovf_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
                  if (in_last) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Result outputs come straight from the running registers.
   always_comb begin
      out_max = max_q;
      out_idx = idx_q;
      out_cnt = cnt_q;
      out_ovf = ovf_q;
   end

endmodule

// File: tb/tb_frame_max_tracker.sv
// Self-checking bench for frame_max_tracker: two instances (IDX_W = 4 and
// IDX_W = 2) share one stimulus stream and are compared every cycle against
// a frame-level model that keeps the accepted samples of the open frame.
module tb_frame_max_tracker;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_last;
   logic       out_ready;

   logic       a_in_ready, a_out_valid, a_out_ovf;
   logic [3:0] a_out_max;
   logic [3:0] a_out_idx;
   logic [4:0] a_out_cnt;

   logic       b_in_ready, b_out_valid, b_out_ovf;
   logic [3:0] b_out_max;
   logic [1:0] b_out_idx;
   logic [2:0] b_out_cnt;

   int errors = 0;
   int checks = 0;

   int q[$];
   bit m_done = 1'b0;

   frame_max_tracker #(.IDX_W(4)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (a_in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (a_out_valid),
      .out_ready (out_ready),
      .out_max   (a_out_max),
      .out_idx   (a_out_idx),
      .out_cnt   (a_out_cnt),
      .out_ovf   (a_out_ovf)
   );

   frame_max_tracker #(.IDX_W(2)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (b_in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (b_out_valid),
      .out_ready (out_ready),
      .out_max   (b_out_max),
      .out_idx   (b_out_idx),
      .out_cnt   (b_out_cnt),
      .out_ovf   (b_out_ovf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected result of the open frame for a given index width, straight
   // from the frame contents: first position of the maximum, saturating
   // count, overflow when the frame is longer than 2^w.
   function automatic void frameExpect(input int w, output int emax, output int eidx,
                                       output int ecnt, output int eovf);
      int n;
      int cap;
      int first;
      n = q.size();
      cap = 1 << w;
      emax = -1;
      first = 0;
      for (int i = 0; i < n; i++) begin
         if (q[i] > emax) begin
            emax = q[i];
            first = i;
         end
      end
      eidx = (first > cap - 1) ? cap - 1 : first;
      ecnt = (n > cap) ? cap : n;
      eovf = (n > cap) ? 1 : 0;
   endfunction

   task automatic checkAll();
      int emax, eidx, ecnt, eovf;
      checkOutput("a_in_ready", int'(a_in_ready), int'(!m_done && !reset));
      checkOutput("b_in_ready", int'(b_in_ready), int'(!m_done && !reset));
      checkOutput("a_out_valid", int'(a_out_valid), int'(m_done));
      checkOutput("b_out_valid", int'(b_out_valid), int'(m_done));
      if (q.size() > 0) begin
         frameExpect(4, emax, eidx, ecnt, eovf);
         checkOutput("a_max", int'(a_out_max), emax);
         checkOutput("a_idx", int'(a_out_idx), eidx);
         checkOutput("a_cnt", int'(a_out_cnt), ecnt);
         checkOutput("a_ovf", int'(a_out_ovf), eovf);
         frameExpect(2, emax, eidx, ecnt, eovf);
         checkOutput("b_max", int'(b_out_max), emax);
         checkOutput("b_idx", int'(b_out_idx), eidx);
         checkOutput("b_cnt", int'(b_out_cnt), ecnt);
         checkOutput("b_ovf", int'(b_out_ovf), eovf);
      end
   endtask

   // One clock cycle: drive inputs, advance the model at the edge, check
   // the DUT outputs half a cycle later.
   task automatic applyStimulus(input bit rst, input bit v, input int d,
                                input bit l, input bit r);
      reset = rst;
      in_valid = v;
      in_data = 4'(d);
      in_last = l;
      out_ready = r;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_done = 1'b0;
      end else if (m_done) begin
         if (r) begin
            m_done = 1'b0;
            q.delete();
         end
      end else if (v) begin
         q.push_back(d & 15);
         if (l) m_done = 1'b1;
      end
      @(negedge clk);
      checkAll();
   endtask

   task automatic sendFrame(input int vals[$]);
      for (int i = 0; i < vals.size(); i++) begin
         applyStimulus(1'b0, 1'b1, vals[i], (i == vals.size() - 1), 1'b0);
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = 4'd0;
      in_last = 1'b0;
      out_ready = 1'b0;

      applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 5, 1'b1, 1'b1);
      checkOutput("rst_a_max", int'(a_out_max), 0);
      checkOutput("rst_a_idx", int'(a_out_idx), 0);
      checkOutput("rst_a_cnt", int'(a_out_cnt), 0);
      checkOutput("rst_a_ovf", int'(a_out_ovf), 0);
      checkOutput("rst_b_cnt", int'(b_out_cnt), 0);

      // Frame 3, 9, 9, 2 with the consumer always ready.
      applyStimulus(1'b0, 1'b1, 3, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 9, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 9, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 2, 1'b1, 1'b1);
      checkOutput("t1_max", int'(a_out_max), 9);
      checkOutput("t1_idx", int'(a_out_idx), 1);
      checkOutput("t1_cnt", int'(a_out_cnt), 4);
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
      checkOutput("t1_valid_one_cycle", int'(a_out_valid), 0);

      // Single-beat frame of 15.
      applyStimulus(1'b0, 1'b1, 15, 1'b1, 1'b0);
      checkOutput("t2_valid", int'(a_out_valid), 1);
      checkOutput("t2_max", int'(a_out_max), 15);
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);

      // All-zero frame held for five cycles of back-pressure.
      sendFrame('{0, 0, 0});
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 7, 1'b0, 1'b0);
      checkOutput("t3_cnt", int'(a_out_cnt), 3);
      applyStimulus(1'b0, 1'b1, 7, 1'b0, 1'b1);
      checkOutput("t3_ready_after", int'(a_in_ready), 1);

      // Overflow on the narrow instance.
      sendFrame('{1, 2, 3, 4, 8});
      checkOutput("t4_b_idx", int'(b_out_idx), 3);
      checkOutput("t4_b_ovf", int'(b_out_ovf), 1);
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);

      // Reset in the middle of a frame discards it.
      applyStimulus(1'b0, 1'b1, 7, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 5, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1, 1'b1, 1'b0);
      checkOutput("t5_max", int'(a_out_max), 1);
      checkOutput("t5_cnt", int'(a_out_cnt), 1);
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);

      // Stall inside a frame.
      applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 9, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 6, 1'b1, 1'b0);
      checkOutput("t6_idx", int'(a_out_idx), 1);
      checkOutput("t6_cnt", int'(a_out_cnt), 2);
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);

      // Random traffic: short frames, then long frames that overflow.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(99) == 0, $urandom_range(9) < 7,
                       int'($urandom_range(15)), $urandom_range(4) == 0,
                       $urandom_range(1) == 1);
      end
      for (int i = 0; i < 4000; i++) begin
         applyStimulus($urandom_range(499) == 0, $urandom_range(9) < 7,
                       int'($urandom_range(15)), $urandom_range(49) == 0,
                       $urandom_range(1) == 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
